// File: rtl/pixie_pkg.sv
// rtl/pixie_pkg.sv - shared types and constants for the Pixie DMA responder
//
// Contents:
//   PIXIE_ADDR_W       default request / RAM address width
//   PIXIE_RAM_LAT_MIN  smallest supported RAM read latency
//   PIXIE_RAM_LAT_MAX  largest supported RAM read latency
//   PIXIE_MAX_WAIT     default cpu_busy wait limit
//   pixie_state_e      responder FSM states (ST_PREFETCH only with PIXIE_DMA_PREFETCH_EN)
package pixie_pkg;

    localparam int unsigned PIXIE_ADDR_W      = 16;
    localparam int unsigned PIXIE_RAM_LAT_MIN = 1;
    localparam int unsigned PIXIE_RAM_LAT_MAX = 3;
    localparam int unsigned PIXIE_MAX_WAIT    = 15;

`ifdef PIXIE_DMA_PREFETCH_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ,
        ST_ACK,
        ST_PREFETCH
    } pixie_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ,
        ST_ACK
    } pixie_state_e;
`endif

endpackage

// File: rtl/pixie_dma_prefetch.sv
// rtl/pixie_dma_prefetch.sv - tagged single-byte read-ahead buffer
//
// Ports:
//   clk, reset        bus clock, synchronous active-low reset
//   clk_enable_i      bus clock enable; buffer state changes only when high
//   fill_i            load fill_data_i tagged with fill_addr_i, marks buffer valid
//   fill_addr_i       address of the byte being loaded
//   fill_data_i       byte being loaded
//   inval_i           drop the buffered byte (wins over a simultaneous fill)
//   lookup_addr_i     address being requested
//   hit_o             buffer valid and tag equals lookup_addr_i
//   data_o            buffered byte
module pixie_dma_prefetch
    import pixie_pkg::*;
#(
    parameter int unsigned ADDR_W = PIXIE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [7:0]        fill_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [7:0]        data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [7:0]        data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clk_enable_i) begin
            // A frame boundary landing on the fill cycle must still discard the byte.
            if (inval_i) begin
                valid_q <= 1'b0;
            end else if (fill_i) begin
                valid_q <= 1'b1;
                tag_q   <= fill_addr_i;
                data_q  <= fill_data_i;
            end
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/pixie_dma_responder.sv
// rtl/pixie_dma_responder.sv - memory-side responder for the Pixie video DMA read port
//
// Optional feature macro: PIXIE_DMA_PREFETCH_EN (read-ahead of ram_addr+1 after each ack).
//
// Ports:
//   clk, reset     CPU bus clock, synchronous active-low reset
//   clk_enable     bus clock enable; every register advances only when high
//   dma_req        Pixie read request (level, held until dma_ack)
//   dma_addr       Pixie read address
//   dma_data       returned byte, valid in the ack cycle and held afterwards
//   dma_ack        one-enabled-cycle completion pulse
//   cpu_busy       CPU is mid-access on the shared bus
//   cpu_hold       stalls the CPU while the responder owns the bus
//   ram_addr       RAM read address
//   ram_rd         RAM read strobe
//   ram_data       RAM read data, valid RAM_LAT enabled cycles after ram_rd
//   frame_int      Pixie start-of-frame marker
//   dma_count      bytes served since the last frame_int rising edge
//   err_timeout    sticky: cpu_busy outlasted MAX_WAIT
module pixie_dma_responder
    import pixie_pkg::*;
#(
    parameter int unsigned ADDR_W   = PIXIE_ADDR_W,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned MAX_WAIT = PIXIE_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [7:0]        dma_data,
    output logic              dma_ack,
    input  logic              cpu_busy,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    input  logic              frame_int,
    output logic [15:0]       dma_count,
    output logic              err_timeout
);

    localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RAM_LAT);

    pixie_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        dma_data_q, dma_data_d;
    logic [15:0]       dma_count_q, dma_count_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        lat_q, lat_d;
    logic              frame_q;

    logic frame_rise;
    logic timeout_now;
    logic grant_rd;
    logic ack_now;

    assign frame_rise  = frame_int && !frame_q;
    assign ack_now     = (state_q == ST_ACK);
    // The last permitted busy cycle aborts the CPU access and reads anyway.
    assign timeout_now = cpu_busy && (wait_q == WAIT_LAST);
    // In GRANT the read strobe fires in the same cycle the bus is won, so
    // READ only has to count out the remaining RAM latency.
    assign grant_rd    = (state_q == ST_GRANT) && (!cpu_busy || timeout_now);

`ifdef PIXIE_DMA_PREFETCH_EN
    logic       pf_hit;
    logic [7:0] pf_data;
    logic       pf_fill;
    logic       pf_inval;

    assign pf_fill  = (state_q == ST_PREFETCH) && (lat_q == LAT_LAST);
    assign pf_inval = frame_rise || ((state_q == ST_IDLE) && dma_req && !pf_hit);

    pixie_dma_prefetch #(
        .ADDR_W (ADDR_W)
    ) u_prefetch (
        .clk           (clk),
        .reset         (reset),
        .clk_enable_i  (clk_enable),
        .fill_i        (pf_fill),
        .fill_addr_i   (ram_addr_q),
        .fill_data_i   (ram_data),
        .inval_i       (pf_inval),
        .lookup_addr_i (dma_addr),
        .hit_o         (pf_hit),
        .data_o        (pf_data)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
`ifdef PIXIE_DMA_PREFETCH_EN
                    state_d = pf_hit ? ST_ACK : ST_GRANT;
`else
                    state_d = ST_GRANT;
`endif
                end
            end
            ST_GRANT: begin
                if (grant_rd) state_d = ST_READ;
            end
            ST_READ: begin
                if (lat_q == LAT_LAST) state_d = ST_ACK;
            end
            ST_ACK: begin
`ifdef PIXIE_DMA_PREFETCH_EN
                state_d = cpu_busy ? ST_IDLE : ST_PREFETCH;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef PIXIE_DMA_PREFETCH_EN
            ST_PREFETCH: begin
                if (lat_q == LAT_LAST) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ram_rd   = grant_rd;
`ifdef PIXIE_DMA_PREFETCH_EN
        if ((state_q == ST_PREFETCH) && (lat_q == 2'd0)) ram_rd = 1'b1;
`endif
        cpu_hold = (state_q != ST_IDLE);
        dma_ack  = ack_now;
    end

    // Datapath next values
    always_comb begin
        ram_addr_d  = ram_addr_q;
        dma_data_d  = dma_data_q;
        wait_d      = wait_q;
        lat_d       = lat_q;
        err_d       = err_q;
        dma_count_d = dma_count_q;

        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    ram_addr_d = dma_addr;
`ifdef PIXIE_DMA_PREFETCH_EN
                    if (pf_hit) dma_data_d = pf_data;
`endif
                end
            end
            ST_GRANT: begin
                if (grant_rd) begin
                    wait_d = '0;
                    // One latency cycle has already elapsed when READ is entered.
                    lat_d  = 2'd1;
                    if (cpu_busy) err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_READ: begin
                if (lat_q == LAT_LAST) begin
                    dma_data_d = ram_data;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_ACK: begin
`ifdef PIXIE_DMA_PREFETCH_EN
                if (!cpu_busy) begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    lat_d      = 2'd0;
                end
`endif
            end
`ifdef PIXIE_DMA_PREFETCH_EN
            ST_PREFETCH: begin
                lat_d = lat_q + 2'd1;
            end
`endif
            default: ;
        endcase

        // A frame edge restarts the count but still credits an ack in the same cycle.
        if (frame_rise) begin
            dma_count_d = {15'd0, ack_now};
        end else if (ack_now) begin
            dma_count_d = dma_count_q + 16'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            dma_data_q  <= '0;
            dma_count_q <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            lat_q       <= '0;
            frame_q     <= 1'b0;
        end else if (clk_enable) begin
            ram_addr_q  <= ram_addr_d;
            dma_data_q  <= dma_data_d;
            dma_count_q <= dma_count_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            lat_q       <= lat_d;
            frame_q     <= frame_int;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign dma_data    = dma_data_q;
    assign dma_count   = dma_count_q;
    assign err_timeout = err_q;

endmodule
